avl_readback_regs: RTL

- Avalon-MM read-side responder for the game's memory-mapped register block; the complement of the existing write-address decoder.
- Returns software-written register contents, hardware event counters, the round number, a read-to-clear sticky status word and an ID constant to the CPU.
- Fixed read latency of 1 cycle; sits beside the write decoder on the same AVL_CS/AVL_ADDR slave.

---
 rtl/avl_readback_regs.sv | 122 ++++++++++++
 1 files changed

// File: rtl/avl_readback_regs.sv
// avl_readback_regs
//   Avalon-MM read-side responder for the game's register block. Returns the
//   software registers, hit/shot event counters, the round number, a
//   read-to-clear sticky status word and a fixed ID. Read latency is exactly
//   one cycle with no wait states; back-to-back reads are supported.
//
// Ports
//   CLK, RESET_N          clock (rising edge), async active-low reset
//   AVL_CS, AVL_READ      read accepted when both are high at a rising edge
//   AVL_ADDR[3:0]         word address
//   AVL_READDATA[31:0]    registered read data, held when no read is accepted
//   AVL_READDATAVALID     one-cycle pulse qualifying AVL_READDATA
//   REGS_IN[255:0]        software registers 0..7, reg k = REGS_IN[32k+31:32k]
//   ROUND[3:0]            current round number
//   SHOT/HIT/ESCAPE/ROUND_END_PULSE  single-cycle event pulses
//   CNT_CLR               synchronous clear of both counters
//
// Address map
//   0..7 REGS_IN[k]   8 hit count   9 shot count   10 {28'b0, ROUND}
//   11..13 zero       14 status {ROUND_END, ESCAPE, HIT, SHOT}, read-to-clear
//   15 ID_VALUE
module avl_readback_regs #(
  parameter logic [31:0] ID_VALUE = 32'hD0C4_0001,
  parameter int unsigned CNT_W    = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_READDATA,
  output logic         AVL_READDATAVALID,
  input  logic [255:0] REGS_IN,
  input  logic [3:0]   ROUND,
  input  logic         SHOT_PULSE,
  input  logic         HIT_PULSE,
  input  logic         ESCAPE_PULSE,
  input  logic         ROUND_END_PULSE,
  input  logic         CNT_CLR
);

  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] shot_cnt;
  logic [3:0]       status;
  logic             rd_accept;
  logic             status_rd;
  logic [31:0]      hit_word;
  logic [31:0]      shot_word;
  logic [31:0]      rd_word;

  assign rd_accept = AVL_CS & AVL_READ;
  assign status_rd = rd_accept && (AVL_ADDR == 4'd14);

  // Hit counter: clear beats increment, saturates at all-ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt <= '0;
    end else if (CNT_CLR) begin
      hit_cnt <= '0;
    end else if (HIT_PULSE && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

  // Shot counter: same rules as the hit counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shot_cnt <= '0;
    end else if (CNT_CLR) begin
      shot_cnt <= '0;
    end else if (SHOT_PULSE && (shot_cnt != '1)) begin
      shot_cnt <= shot_cnt + 1'b1;
    end
  end

  // Sticky flags. A status read clears them, but a pulse arriving on the
  // clearing edge is OR'd in afterwards so that event is not lost.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      status <= '0;
    end else begin
      status <= (status_rd ? 4'b0000 : status)
              | {ROUND_END_PULSE, ESCAPE_PULSE, HIT_PULSE, SHOT_PULSE};
    end
  end

  // Zero-extend counters; written as a slice so CNT_W == 32 needs no
  // zero-width replication.
  always_comb begin
    hit_word  = '0;
    shot_word = '0;
    hit_word[CNT_W-1:0]  = hit_cnt;
    shot_word[CNT_W-1:0] = shot_cnt;
  end

  always_comb begin
    rd_word = '0;
    case (AVL_ADDR)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: rd_word = REGS_IN[{AVL_ADDR[2:0], 5'd0} +: 32];
      4'd8:                   rd_word = hit_word;
      4'd9:                   rd_word = shot_word;
      4'd10:                  rd_word = {28'd0, ROUND};
      4'd14:                  rd_word = {28'd0, status};
      4'd15:                  rd_word = ID_VALUE;
      default:                rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AVL_READDATA      <= '0;
      AVL_READDATAVALID <= 1'b0;
    end else begin
      AVL_READDATAVALID <= rd_accept;
      if (rd_accept) begin
        AVL_READDATA <= rd_word;
      end
    end
  end

endmodule
